// File: rtl/fetch_controller_if.sv
// Fetch controller bus bundle: instruction-memory request side, decode handoff side,
// branch redirect input and the transfer counter.
interface fetch_controller_if #(
   parameter int DATA_W = 32
);
   logic              enable;
   logic              imem_req;
   logic [15:0]       imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic              instr_valid;
   logic [DATA_W-1:0] instr;
   logic [15:0]       instr_pc;
   logic              instr_ready;
   logic              redirect;
   logic [20:0]       redirect_offset;
   logic [15:0]       issued_cnt;

   modport master (
      input  enable, imem_ack, imem_rdata, instr_ready, redirect, redirect_offset,
      output imem_req, imem_addr, instr_valid, instr, instr_pc, issued_cnt
   );

   modport slave (
      output enable, imem_ack, imem_rdata, instr_ready, redirect, redirect_offset,
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, issued_cnt
   );
endinterface

// File: rtl/fetch_controller.sv
// Single-outstanding instruction fetcher: request -> hold for decode, one fetch per 2 cycles at best.
// Decode stalls keep the word held; a redirect squashes in-flight data and refetches at the branch target.
module fetch_controller #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          DATA_W   = 32
) (
   input logic          clk,
   input logic          reset,
   fetch_controller_if.master bus
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD, SQUASH} state_t;

   state_t            state, state_nxt;
   logic [15:0]       pc, pc_nxt;
   logic [15:0]       last_pc;
   logic [15:0]       req_addr;
   logic [15:0]       instr_pc_q;
   logic [15:0]       cnt_q;
   logic [15:0]       target;
   logic [DATA_W-1:0] instr_q;
   logic              load_req;
   logic              capture;
   logic              xfer;

   // Sign extension is implicit: the 21-bit sum truncated to 16 bits is the same modulo 2^16.
   assign target = 16'({5'd0, last_pc} + bus.redirect_offset);
   assign xfer   = (state == HOLD) && bus.instr_ready;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      load_req  = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.redirect) begin
               pc_nxt = target;
            end else if (bus.enable) begin
               state_nxt = FETCH;
               load_req  = 1'b1;
            end
         end
         FETCH: begin
            if (bus.redirect) begin
               pc_nxt = target;
               if (!bus.imem_ack) begin
                  state_nxt = SQUASH;
               end else if (bus.enable) begin
                  state_nxt = FETCH;
                  load_req  = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (bus.imem_ack) begin
               capture   = 1'b1;
               pc_nxt    = pc + 16'd4;
               state_nxt = HOLD;
            end
         end
         SQUASH: begin
            // The old address stays on the bus; its data is dropped when it finally arrives.
            if (bus.redirect) pc_nxt = target;
            if (bus.imem_ack) begin
               if (bus.enable) begin
                  state_nxt = FETCH;
                  load_req  = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         HOLD: begin
            if (bus.redirect) pc_nxt = target;
            if (bus.redirect || xfer) begin
               if (bus.enable) begin
                  state_nxt = FETCH;
                  load_req  = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         last_pc    <= RESET_PC;
         req_addr   <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         cnt_q      <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (load_req) req_addr <= pc_nxt;
         if (capture) begin
            instr_q    <= bus.imem_rdata;
            instr_pc_q <= pc;
         end
         if (xfer) begin
            last_pc <= instr_pc_q;
            cnt_q   <= cnt_q + 16'd1;
         end
      end
   end

   assign bus.imem_req    = (state == FETCH) || (state == SQUASH);
   assign bus.imem_addr   = req_addr;
   assign bus.instr_valid = (state == HOLD);
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.issued_cnt  = cnt_q;
endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: per-cycle vector table plus a transfer scoreboard and hand-written corner cases.
module tb_fetch_controller;
   localparam logic [15:0] RP = 16'h0000;
   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;
   localparam int NV = 25;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_controller_if #(.DATA_W(32)) bus();
   fetch_controller #(.RESET_PC(RP), .DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Memory returns a word that encodes its own address.
   assign bus.imem_rdata = {16'hC0DE, bus.imem_addr};

   typedef struct {
      logic        en, ack, rdy, redir;
      logic [20:0] off;
      logic        push;
      logic        exp_req;
      logic [15:0] exp_addr;
      logic        exp_valid;
      logic [15:0] exp_pc;
      logic [15:0] exp_cnt;
   } vec_t;

   typedef struct packed {
      logic [15:0] pc;
      logic [31:0] dat;
   } exp_t;

   vec_t vec [NV];
   exp_t sb [$];
   exp_t e;
   int total  = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic en, input logic ack, input logic rdy, input logic redir,
                               input logic [20:0] off, input logic push, input logic ereq,
                               input logic [15:0] eaddr, input logic evld, input logic [15:0] epc,
                               input logic [15:0] ecnt);
      vec_t v;
      v.en = en; v.ack = ack; v.rdy = rdy; v.redir = redir; v.off = off; v.push = push;
      v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evld; v.exp_pc = epc; v.exp_cnt = ecnt;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bus.enable = N; bus.imem_ack = N; bus.instr_ready = N;
      bus.redirect = N; bus.redirect_offset = '0;

      //            en ack rdy rdr offset       push req addr      vld pc        cnt
      vec[0]  = mk(Y, Y, Y, N, 21'h0,       N, N, 16'h0000, N, 16'h0000, 16'd0);
      vec[1]  = mk(Y, Y, Y, N, 21'h0,       Y, Y, 16'h0000, N, 16'h0000, 16'd0);
      vec[2]  = mk(Y, Y, Y, N, 21'h0,       N, N, 16'h0000, Y, 16'h0000, 16'd0);
      vec[3]  = mk(Y, Y, Y, N, 21'h0,       Y, Y, 16'h0004, N, 16'h0000, 16'd1);
      vec[4]  = mk(Y, Y, Y, N, 21'h0,       N, N, 16'h0000, Y, 16'h0004, 16'd1);
      vec[5]  = mk(Y, Y, Y, N, 21'h0,       Y, Y, 16'h0008, N, 16'h0000, 16'd2);
      vec[6]  = mk(Y, Y, Y, N, 21'h0,       N, N, 16'h0000, Y, 16'h0008, 16'd2);
      vec[7]  = mk(Y, Y, Y, N, 21'h0,       Y, Y, 16'h000C, N, 16'h0000, 16'd3);
      // Decode stalls five cycles; the held word must not move and no request may start.
      vec[8]  = mk(Y, Y, N, N, 21'h0,       N, N, 16'h0000, Y, 16'h000C, 16'd3);
      vec[9]  = mk(Y, Y, N, N, 21'h0,       N, N, 16'h0000, Y, 16'h000C, 16'd3);
      vec[10] = mk(Y, Y, N, N, 21'h0,       N, N, 16'h0000, Y, 16'h000C, 16'd3);
      vec[11] = mk(Y, Y, N, N, 21'h0,       N, N, 16'h0000, Y, 16'h000C, 16'd3);
      vec[12] = mk(Y, Y, N, N, 21'h0,       N, N, 16'h0000, Y, 16'h000C, 16'd3);
      vec[13] = mk(Y, Y, Y, N, 21'h0,       N, N, 16'h0000, Y, 16'h000C, 16'd3);
      vec[14] = mk(Y, Y, Y, N, 21'h0,       Y, Y, 16'h0010, N, 16'h0000, 16'd4);
      vec[15] = mk(Y, Y, Y, N, 21'h0,       N, N, 16'h0000, Y, 16'h0010, 16'd4);
      // last_pc=0x10, redirect -8 with the ack three cycles late: target 0x08.
      vec[16] = mk(Y, N, Y, Y, 21'h1FFFF8,  N, Y, 16'h0014, N, 16'h0000, 16'd5);
      vec[17] = mk(Y, N, Y, N, 21'h0,       N, Y, 16'h0014, N, 16'h0000, 16'd5);
      vec[18] = mk(Y, N, Y, N, 21'h0,       N, Y, 16'h0014, N, 16'h0000, 16'd5);
      vec[19] = mk(Y, Y, Y, N, 21'h0,       N, Y, 16'h0014, N, 16'h0000, 16'd5);
      vec[20] = mk(Y, Y, Y, N, 21'h0,       Y, Y, 16'h0008, N, 16'h0000, 16'd5);
      // Redirect +0x20 alongside a transfer: counted, target from old last_pc 0x10 -> 0x30.
      vec[21] = mk(Y, Y, Y, Y, 21'h000020,  N, N, 16'h0000, Y, 16'h0008, 16'd5);
      vec[22] = mk(Y, Y, Y, N, 21'h0,       Y, Y, 16'h0030, N, 16'h0000, 16'd6);
      vec[23] = mk(Y, Y, Y, N, 21'h0,       N, N, 16'h0000, Y, 16'h0030, 16'd6);
      vec[24] = mk(Y, N, Y, N, 21'h0,       N, Y, 16'h0034, N, 16'h0000, 16'd7);

      tick();
      chk("rst req", 32'(bus.imem_req), 32'd0);
      chk("rst valid", 32'(bus.instr_valid), 32'd0);
      chk("rst instr", bus.instr, 32'd0);
      chk("rst instr_pc", 32'(bus.instr_pc), 32'd0);
      chk("rst cnt", 32'(bus.issued_cnt), 32'd0);
      tick();
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         bus.enable = vec[i].en; bus.imem_ack = vec[i].ack; bus.instr_ready = vec[i].rdy;
         bus.redirect = vec[i].redir; bus.redirect_offset = vec[i].off;
         chk($sformatf("r%0d req", i), 32'(bus.imem_req), 32'(vec[i].exp_req));
         if (vec[i].exp_req) chk($sformatf("r%0d addr", i), 32'(bus.imem_addr), 32'(vec[i].exp_addr));
         chk($sformatf("r%0d valid", i), 32'(bus.instr_valid), 32'(vec[i].exp_valid));
         if (vec[i].exp_valid) begin
            chk($sformatf("r%0d instr_pc", i), 32'(bus.instr_pc), 32'(vec[i].exp_pc));
            chk($sformatf("r%0d instr", i), bus.instr, {16'hC0DE, vec[i].exp_pc});
         end
         chk($sformatf("r%0d cnt", i), 32'(bus.issued_cnt), 32'(vec[i].exp_cnt));
         if (bus.instr_valid && vec[i].rdy) begin
            if (sb.size() == 0) begin
               total++;
               $display("FAIL r%0d sb: transfer of pc %h with nothing expected", i, bus.instr_pc);
            end else begin
               e = sb.pop_front();
               chk($sformatf("r%0d sb pc", i), 32'(bus.instr_pc), 32'(e.pc));
               chk($sformatf("r%0d sb dat", i), bus.instr, e.dat);
            end
         end
         if (vec[i].push) sb.push_back({vec[i].exp_addr, 16'hC0DE, vec[i].exp_addr});
         tick();
      end
      chk("sb empty", sb.size(), 32'd0);
      bus.redirect = N;

      // Asynchronous reset in the middle of an outstanding request.
      chk("pre-rst req", 32'(bus.imem_req), 32'd1);
      #3;
      reset = 1'b1;
      bus.imem_ack = Y;
      #1;
      chk("async req", 32'(bus.imem_req), 32'd0);
      chk("async valid", 32'(bus.instr_valid), 32'd0);
      chk("async instr", bus.instr, 32'd0);
      chk("async instr_pc", 32'(bus.instr_pc), 32'd0);
      chk("async cnt", 32'(bus.issued_cnt), 32'd0);
      tick();
      chk("in-rst req", 32'(bus.imem_req), 32'd0);
      reset = 1'b0; bus.enable = Y; bus.instr_ready = Y;
      chk("post-rst idle", 32'(bus.imem_req), 32'd0);
      tick();
      chk("restart req", 32'(bus.imem_req), 32'd1);
      chk("restart addr", 32'(bus.imem_addr), 32'(RP));
      tick();
      chk("restart valid", 32'(bus.instr_valid), 32'd1);
      chk("restart instr_pc", 32'(bus.instr_pc), 32'(RP));
      chk("restart instr", bus.instr, {16'hC0DE, RP});
      tick();
      chk("restart cnt", 32'(bus.issued_cnt), 32'd1);
      chk("restart next addr", 32'(bus.imem_addr), 32'(RP + 16'd4));

      // Address and counter wraparound.
      reset = 1'b1; bus.enable = N;
      tick();
      reset = 1'b0;
      bus.redirect = Y; bus.redirect_offset = 21'h1FFFFC;
      tick();
      bus.redirect = N;
      chk("idle redirect stays", 32'(bus.imem_req), 32'd0);
      force dut.cnt_q = 16'hFFFF;
      #1;
      release dut.cnt_q;
      chk("cnt preset", 32'(bus.issued_cnt), 32'h0000FFFF);
      bus.enable = Y; bus.imem_ack = Y; bus.instr_ready = Y;
      tick();
      chk("wrap req", 32'(bus.imem_req), 32'd1);
      chk("wrap addr FFFC", 32'(bus.imem_addr), 32'h0000FFFC);
      tick();
      chk("wrap valid", 32'(bus.instr_valid), 32'd1);
      chk("wrap instr_pc", 32'(bus.instr_pc), 32'h0000FFFC);
      tick();
      chk("wrap next addr", 32'(bus.imem_addr), 32'd0);
      chk("wrap cnt", 32'(bus.issued_cnt), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
